temp_conv_engine: RTL and testbench
===================================

Name: temp_conv_engine

Overview:
Multi-channel, handshaked Celsius/Fahrenheit conversion engine using two synchronous lookup ROMs. It accepts one conversion request at a time, range-checks it, looks it up, and returns the result on a ready/valid output. It also keeps a per-channel last-result bank that the seven-segment display path reads asynchronously. It sits between the switch/sensor front end and Seven_Seg_Driver, and replaces the combinational converter.

Parameters:
WIDTH, 8, temperature word width (unsigned); must be >= 8 to hold 212
NUM_CH, 4, number of source channels tracked in the result bank
CH_W, $clog2(NUM_CH), channel index width (derived)
ERR_W, 16, width of saturating out-of-range counter
C2F_FILE, "c2f.mem", ROM image indexed by Celsius 0..100, holds Fahrenheit
F2C_FILE, "f2c.mem", ROM image indexed by (Fahrenheit - 32) 0..180, holds Celsius

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  engine can accept a request
in_temp  in  WIDTH  input temperature
in_fmt  in  1  1 = C->F, 0 = F->C
in_ch  in  CH_W  source channel tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_temp  out  WIDTH  converted value; 0 on error
out_fmt  out  1  echo of the request fmt
out_ch  out  CH_W  echo of the request channel
out_err  out  1  request was out of range
rd_ch  in  CH_W  bank read select
rd_temp  out  WIDTH  last result for rd_ch (combinational read)
rd_err  out  1  error flag of that result
rd_vld  out  1  channel has produced a result since reset
err_count  out  ERR_W  saturating count of out-of-range requests

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE. out_valid=0, out_temp=0, out_err=0, out_fmt=0, out_ch=0.
  - All bank entries are cleared (temp 0, err 0, vld 0). err_count=0.
  - Any in-flight request is discarded, with no output.
- FSM states are IDLE -> LOOKUP -> CAPTURE -> RESP -> IDLE.
- in_ready = (state==IDLE). A request is accepted on a clock edge with in_valid && in_ready.
- Accept edge k:
  - Latch in_temp, in_fmt and in_ch.
  - Compute the range flag combinationally from in_temp. C->F is valid for 0..100. F->C is valid for 32..212.
  - Go to LOOKUP.
- LOOKUP: the ROM address is driven from the latched request (C->F: temp; F->C: temp-32). If out of range, the address is forced to 0. At the next edge the ROM registers its data, and state goes to CAPTURE.
- CAPTURE:
  - Select ROM data by fmt. Force it to 0 if out of range.
  - At the next edge (k+2), load the out_* registers and write the bank entry [ch] (temp, err, vld=1).
  - Increment err_count on error, saturating at all-ones.
  - Go to RESP.
- Latency is fixed: out_valid is high from edge k+2, for both in-range and error requests.
- RESP:
  - out_valid=1 and out_* are held stable until out_valid && out_ready.
  - On that edge, go to IDLE and set out_valid to 0.
  - in_valid is not accepted during RESP. Minimum spacing is 4 cycles per request.
- Inputs are unsigned; negative temperatures are unsupported. Widths above 8 zero-extend the ROM data.
- ROM contents are rounded half-up (F->C: 98->37; C->F: 37->99). Entries outside the valid range are don't-care.
- Bank read is combinational from registers. Reading the channel that is being written returns the old value until the write edge.
- rd_ch/in_ch >= NUM_CH (non-power-of-2 NUM_CH): writes are dropped and reads return zeros.

Decomposition:
- Package temp_conv_pkg holds:
  - typedef enum fmt_e {FMT_F2C=0, FMT_C2F=1}
  - typedef enum state_e {IDLE, LOOKUP, CAPTURE, RESP}
  - localparams C_MIN=0, C_MAX=100, F_MIN=32, F_MAX=212
- One sub-module, conv_rom: a synchronous read ROM with params WIDTH, ADDR_W and MEM_FILE, and 1-cycle latency. It is instantiated twice (C->F and F->C).

Test Plan:
- Reset then C->F in_temp=100, ch=2 -> out_valid 2 edges after accept; out_temp=212, out_err=0, out_ch=2; rd_ch=2 gives 212/vld=1.
- F->C in_temp=32, then 212, then 98 -> 0, 100, 37; in_ready low from accept until the RESP handshake.
- F->C in_temp=31 and C->F in_temp=101 -> out_temp=0, out_err=1, same 2-edge latency; err_count=2; bank err bit set.
- Backpressure: out_ready=0 for 10 cycles in RESP -> out_* stable, in_ready=0, second in_valid not accepted; accepted 1 cycle after the out_ready handshake.
- Assert rst during LOOKUP of C->F 50 -> out_valid stays 0, all bank vld=0, err_count=0; next request C->F 50 -> 122.
- ERR_W=2, send 5 out-of-range requests -> err_count saturates at 3.

Source files
------------

// File: rtl/temp_conv_pkg.sv
// Shared types, range limits and the built-in conversion ROM images for the
// temperature conversion engine.
package temp_conv_pkg;

  typedef enum logic {
    FMT_F2C = 1'b0,
    FMT_C2F = 1'b1
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    CAPTURE,
    RESP
  } state_e;

  localparam int C_MIN = 0;
  localparam int C_MAX = 100;
  localparam int F_MIN = 32;
  localparam int F_MAX = 212;

  // Both ROMs use one address width: the F->C image needs 181 entries.
  localparam int ROM_AW = 8;

  localparam string C2F_IMAGE = "c2f.mem";
  localparam string F2C_IMAGE = "f2c.mem";

  // Round-half-up conversion tables; entries outside the valid range are 0.
  function automatic int rom_word(input bit is_f2c, input int addr);
    if (is_f2c) begin
      return (addr <= F_MAX - F_MIN) ? (addr * 10 + 9) / 18 : 0;
    end
    return (addr <= C_MAX - C_MIN) ? (addr * 18 + 5) / 10 + F_MIN : 0;
  endfunction

endpackage

// File: rtl/conv_rom.sv
// Synchronous-read conversion ROM, one cycle of latency. The image is selected
// by name from the tables built into temp_conv_pkg.
module conv_rom
  import temp_conv_pkg::*;
#(
  parameter int    WIDTH    = 8,
  parameter int    ADDR_W   = 8,
  parameter string MEM_FILE = "c2f.mem"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [WIDTH-1:0]  data_o
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam bit IS_F2C = (MEM_FILE == F2C_IMAGE);

  logic [WIDTH-1:0] rom [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_img
    assign rom[a] = WIDTH'(rom_word(IS_F2C, a));
  end

  always_ff @(posedge clk) begin
    data_o <= rom[addr_i];
  end

endmodule

// File: rtl/temp_conv_engine.sv
// Handshaked Celsius/Fahrenheit converter with a fixed two-edge latency,
// a per-channel last-result bank and a saturating out-of-range counter.
module temp_conv_engine
  import temp_conv_pkg::*;
#(
  parameter int    WIDTH    = 8,
  parameter int    NUM_CH   = 4,
  parameter int    CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int    ERR_W    = 16,
  parameter string C2F_FILE = "c2f.mem",
  parameter string F2C_FILE = "f2c.mem"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_temp,
  input  logic             in_fmt,
  input  logic [CH_W-1:0]  in_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_temp,
  output logic             out_fmt,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_err,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [WIDTH-1:0] rd_temp,
  output logic             rd_err,
  output logic             rd_vld,
  output logic [ERR_W-1:0] err_count
);

  state_e           state_q;
  logic [WIDTH-1:0] temp_q;
  fmt_e             fmt_q;
  logic [CH_W-1:0]  ch_q;
  logic             range_err_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_temp_q;
  fmt_e             out_fmt_q;
  logic [CH_W-1:0]  out_ch_q;
  logic             out_err_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] bank_temp_q [NUM_CH];
  logic             bank_err_q  [NUM_CH];
  logic             bank_vld_q  [NUM_CH];

  logic              in_range_err;
  logic [ROM_AW-1:0] c2f_addr, f2c_addr;
  logic [WIDTH-1:0]  c2f_data, f2c_data;
  logic [WIDTH-1:0]  cap_temp_d;

  assign in_range_err = (fmt_e'(in_fmt) == FMT_C2F)
                      ? (in_temp > WIDTH'(C_MAX))
                      : (in_temp < WIDTH'(F_MIN)) || (in_temp > WIDTH'(F_MAX));

  // Out-of-range requests read address 0 so the ROM never sees a wild index.
  assign c2f_addr = range_err_q ? '0 : temp_q[ROM_AW-1:0];
  assign f2c_addr = range_err_q ? '0 : ROM_AW'(temp_q - WIDTH'(F_MIN));

  conv_rom #(.WIDTH(WIDTH), .ADDR_W(ROM_AW), .MEM_FILE(C2F_FILE)) u_c2f_rom (
    .clk    (clk),
    .addr_i (c2f_addr),
    .data_o (c2f_data)
  );

  conv_rom #(.WIDTH(WIDTH), .ADDR_W(ROM_AW), .MEM_FILE(F2C_FILE)) u_f2c_rom (
    .clk    (clk),
    .addr_i (f2c_addr),
    .data_o (f2c_data)
  );

  assign cap_temp_d = range_err_q ? '0 : ((fmt_q == FMT_C2F) ? c2f_data : f2c_data);
  assign err_cnt_d  = (range_err_q && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;

  // NOTE: every register in this block uses <= so all state updates see the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      temp_q      <= '0;
      fmt_q       <= FMT_F2C;
      ch_q        <= '0;
      range_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_temp_q  <= '0;
      out_fmt_q   <= FMT_F2C;
      out_ch_q    <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      // NOTE: the bank is a small register file, not a RAM; it must be reset
      // because rd_vld has to report "no result since reset".
      for (int i = 0; i < NUM_CH; i++) begin
        bank_temp_q[i] <= '0;
        bank_err_q[i]  <= 1'b0;
        bank_vld_q[i]  <= 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            temp_q      <= in_temp;
            fmt_q       <= fmt_e'(in_fmt);
            ch_q        <= in_ch;
            range_err_q <= in_range_err;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: state_q <= CAPTURE;
        CAPTURE: begin
          out_valid_q <= 1'b1;
          out_temp_q  <= cap_temp_d;
          out_fmt_q   <= fmt_q;
          out_ch_q    <= ch_q;
          out_err_q   <= range_err_q;
          err_cnt_q   <= err_cnt_d;
          if (int'(ch_q) < NUM_CH) begin
            bank_temp_q[ch_q] <= cap_temp_d;
            bank_err_q[ch_q]  <= range_err_q;
            bank_vld_q[ch_q]  <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_temp  = out_temp_q;
  assign out_fmt   = out_fmt_q;
  assign out_ch    = out_ch_q;
  assign out_err   = out_err_q;
  assign err_count = err_cnt_q;

  // NOTE: outputs get defaults before the guarded read so no latch is inferred.
  always_comb begin
    rd_temp = '0;
    rd_err  = 1'b0;
    rd_vld  = 1'b0;
    if (int'(rd_ch) < NUM_CH) begin
      rd_temp = bank_temp_q[rd_ch];
      rd_err  = bank_err_q[rd_ch];
      rd_vld  = bank_vld_q[rd_ch];
    end
  end

endmodule

// File: tb/tb_temp_conv_engine.sv
// Directed bench for temp_conv_engine: table-driven conversions plus hand
// sequences for backpressure, mid-flight reset and counter saturation.
module tb_temp_conv_engine;
  import temp_conv_pkg::*;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int ERR_W  = 16;

  logic             clk;
  logic             rst;
  logic             in_valid, in_fmt, out_ready;
  logic [WIDTH-1:0] in_temp;
  logic [CH_W-1:0]  in_ch, rd_ch;

  logic             in_ready, out_valid, out_fmt, out_err, rd_err, rd_vld;
  logic [WIDTH-1:0] out_temp, rd_temp;
  logic [CH_W-1:0]  out_ch;
  logic [ERR_W-1:0] err_count;

  logic             s_in_ready, s_out_valid, s_out_fmt, s_out_err, s_rd_err, s_rd_vld;
  logic [WIDTH-1:0] s_out_temp, s_rd_temp;
  logic [CH_W-1:0]  s_out_ch;
  logic [1:0]       s_err_count;

  temp_conv_engine #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_temp(in_temp),
    .in_fmt(in_fmt), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_temp(out_temp),
    .out_fmt(out_fmt), .out_ch(out_ch), .out_err(out_err),
    .rd_ch(rd_ch), .rd_temp(rd_temp), .rd_err(rd_err), .rd_vld(rd_vld),
    .err_count(err_count)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  temp_conv_engine #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_temp(in_temp),
    .in_fmt(in_fmt), .in_ch(in_ch),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_temp(s_out_temp),
    .out_fmt(s_out_fmt), .out_ch(s_out_ch), .out_err(s_out_err),
    .rd_ch(rd_ch), .rd_temp(s_rd_temp), .rd_err(s_rd_err), .rd_vld(s_rd_vld),
    .err_count(s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fmt;
    logic [7:0] temp;
    logic [1:0] ch;
    logic [7:0] exp_temp;
    logic       exp_err;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_temp [NUM_CH];
  logic       m_err  [NUM_CH];
  logic       m_vld  [NUM_CH];
  int         m_errs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_temp[i] = '0;
      m_err[i]  = 1'b0;
      m_vld[i]  = 1'b0;
    end
    m_errs = 0;
  endtask

  task automatic check_counts();
    check("err_count", err_count, m_errs);
    check("err_count_sat", s_err_count, (m_errs > 3) ? 3 : m_errs);
  endtask

  // One full request: accept at edge k, result at k+2, handshake at k+3.
  task automatic run_vec(input vec_t v);
    check("ready_before_req", in_ready, 1);
    in_fmt   = v.fmt;
    in_temp  = v.temp;
    in_ch    = v.ch;
    rd_ch    = v.ch;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ready_after_accept", in_ready, 0);
    check("valid_at_k", out_valid, 0);
    @(posedge clk); #1;
    check("valid_at_k1", out_valid, 0);
    check("ready_at_k1", in_ready, 0);
    check("bank_old_temp", rd_temp, m_temp[v.ch]);
    check("bank_old_vld", rd_vld, m_vld[v.ch]);
    @(posedge clk); #1;
    m_temp[v.ch] = v.exp_temp;
    m_err[v.ch]  = v.exp_err;
    m_vld[v.ch]  = 1'b1;
    if (v.exp_err) m_errs++;
    check("valid_at_k2", out_valid, 1);
    check("out_temp", out_temp, v.exp_temp);
    check("out_err", out_err, v.exp_err);
    check("out_ch", out_ch, v.ch);
    check("out_fmt", out_fmt, v.fmt);
    check("ready_in_resp", in_ready, 0);
    check("bank_temp", rd_temp, m_temp[v.ch]);
    check("bank_err", rd_err, m_err[v.ch]);
    check("bank_vld", rd_vld, 1);
    check_counts();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_after_hs", out_valid, 0);
    check("ready_after_hs", in_ready, 1);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 8'd100, 2'd2, 8'd212, 1'b0};
    vecs[1] = '{1'b0, 8'd32,  2'd0, 8'd0,   1'b0};
    vecs[2] = '{1'b0, 8'd212, 2'd1, 8'd100, 1'b0};
    vecs[3] = '{1'b0, 8'd98,  2'd3, 8'd37,  1'b0};
    vecs[4] = '{1'b0, 8'd31,  2'd0, 8'd0,   1'b1};
    vecs[5] = '{1'b1, 8'd101, 2'd1, 8'd0,   1'b1};
    vecs[6] = '{1'b1, 8'd37,  2'd2, 8'd99,  1'b0};
    vecs[7] = '{1'b1, 8'd0,   2'd3, 8'd32,  1'b0};

    rst = 1'b1; in_valid = 1'b0; in_fmt = 1'b0; in_temp = '0; in_ch = '0;
    out_ready = 1'b0; rd_ch = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_out_temp", out_temp, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_fmt", out_fmt, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_in_ready", in_ready, 1);
    check_counts();
    for (int c = 0; c < NUM_CH; c++) begin
      rd_ch = CH_W'(c); #1;
      check("rst_bank_vld", rd_vld, 0);
      check("rst_bank_temp", rd_temp, 0);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: result held, second request waits for the handshake.
    run_vec('{1'b1, 8'd50, 2'd0, 8'd122, 1'b0});
    check("ready_idle_bp", in_ready, 1);
    in_fmt = 1'b1; in_temp = 8'd50; in_ch = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_fmt = 1'b0; in_temp = 8'd212; in_ch = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_temp", out_temp, 122);
      check("bp_ch", out_ch, 0);
      check("bp_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_valid", out_valid, 0);
    check("bp_hs_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept_next", in_ready, 0);
    @(posedge clk); #1;
    check("bp2_valid_k1", out_valid, 0);
    @(posedge clk); #1;
    check("bp2_valid", out_valid, 1);
    check("bp2_temp", out_temp, 100);
    check("bp2_ch", out_ch, 1);
    check("bp2_fmt", out_fmt, 0);
    m_temp[0] = 8'd122; m_vld[0] = 1'b1; m_err[0] = 1'b0;
    m_temp[1] = 8'd100; m_vld[1] = 1'b1; m_err[1] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset while the request sits in LOOKUP.
    in_fmt = 1'b1; in_temp = 8'd50; in_ch = 2'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lookup_ready", in_ready, 0);
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", out_valid, 0);
    end
    check("post_rst_ready", in_ready, 1);
    check_counts();
    for (int c = 0; c < NUM_CH; c++) begin
      rd_ch = CH_W'(c); #1;
      check("post_rst_bank_vld", rd_vld, 0);
    end
    run_vec('{1'b1, 8'd50, 2'd3, 8'd122, 1'b0});

    // Five out-of-range requests: wide counter reaches 5, narrow one sticks at 3.
    for (int i = 0; i < 5; i++) begin
      run_vec('{logic'(i % 2), (i % 2 == 1) ? 8'd150 : 8'd10, 2'(i), 8'd0, 1'b1});
    end
    check("final_err_count", err_count, 5);
    check("final_err_count_sat", s_err_count, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
